// File: rtl/bscan_arb_pkg.sv
// Shared types and constants for the BSCAN channel arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bscan_arb_pkg;

    // Width of the saturating statistics counters.
    localparam int CNTW = 16;

    // Default channel configuration used by the header struct.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCHAN = 4;

    // ceil(log2(n)) for n in 2..16; the tag width needed to name n channels.
    function automatic int tag_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    localparam int DEF_TAGW = tag_width(DEF_NCHAN);

    // One BSCAN word: channel tag in the top bits, payload below.
    typedef struct packed {
        logic [DEF_TAGW-1:0]           tag;
        logic [DEF_WIDTH-DEF_TAGW-1:0] payload;
    } hdr_t;

endpackage

// File: rtl/bscan_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo NCHAN.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module bscan_rr_pick #(
    parameter int NCHAN = 4,
    parameter int IW    = 2
) (
    input  logic [NCHAN-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [NCHAN-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    // Scan NCHAN positions starting at the pointer; the first hit wins.
    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int k = 0; k < NCHAN; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NCHAN) j = j - NCHAN;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bscan_chan_arbiter.sv
// Shares one BSCAN word channel among NCHAN requesters (tag+payload up, tag-routed down).
// Latency: req enq -> to_enq 2 cycles; from_enq -> rsp 1 cycle; optional stats via BSCAN_CHAN_ARBITER_STATS_EN.
// Backpressure: 1-entry slot per channel and 1-entry out/in registers; RDY never depends on ENA.
module bscan_chan_arbiter
    import bscan_arb_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int WIDTH = 32,
    parameter int TAGW  = tag_width(NCHAN),
    localparam int PW   = WIDTH - TAGW
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NCHAN-1:0]    req_enq__ENA,
    input  logic [NCHAN*PW-1:0] req_enq_v,
    output logic [NCHAN-1:0]    req_enq__RDY,
    output logic                to_enq__ENA,
    output logic [WIDTH-1:0]    to_enq_v,
    input  logic                to_enq__RDY,
    input  logic                from_enq__ENA,
    input  logic [WIDTH-1:0]    from_enq_v,
    output logic                from_enq__RDY,
    output logic [NCHAN-1:0]    rsp_enq__ENA,
    output logic [PW-1:0]       rsp_enq_v,
    input  logic [NCHAN-1:0]    rsp_enq__RDY
`ifdef BSCAN_CHAN_ARBITER_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [CNTW-1:0]     stat_sent,
    output logic [CNTW-1:0]     stat_drop
`endif
);

    // ---------------- host-bound path ----------------
    logic [NCHAN-1:0] slot_full_q, slot_full_d;
    logic [PW-1:0]    slot_dat_q [NCHAN];
    logic             out_full_q, out_full_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic [TAGW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NCHAN-1:0] pick_gnt;
    logic [TAGW-1:0]  pick_idx;
    logic             pick_any;
    logic             load;

    bscan_rr_pick #(
        .NCHAN (NCHAN),
        .IW    (TAGW)
    ) u_pick (
        .req_i (slot_full_q),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign req_enq__RDY = ~slot_full_q;
    assign to_enq__ENA  = out_full_q & to_enq__RDY;
    assign to_enq_v     = out_word_q;

    // Refill the output register whenever it is empty or draining this cycle.
    assign load = pick_any & (~out_full_q | to_enq__ENA);

    // Next state for slot flags, output register and round-robin pointer.
    always_comb begin
        // ENA only arrives on an empty slot and load only clears a full one, so they never collide.
        slot_full_d = slot_full_q | req_enq__ENA;
        out_full_d  = out_full_q;
        out_word_d  = out_word_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            slot_full_d = slot_full_d & ~pick_gnt;
            out_full_d  = 1'b1;
            out_word_d  = {pick_idx, slot_dat_q[pick_idx]};
            rr_ptr_d    = (pick_idx == TAGW'(NCHAN - 1)) ? '0 : pick_idx + 1'b1;
        end else if (to_enq__ENA) begin
            out_full_d = 1'b0;
        end
    end

    // Control state for the host-bound path; reset discards any held words.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            slot_full_q <= '0;
            out_full_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            out_full_q  <= out_full_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Payload storage; contents are only meaningful while the matching full flag is set.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (req_enq__ENA[i]) slot_dat_q[i] <= req_enq_v[i*PW +: PW];
        end
        out_word_q <= out_word_d;
    end

    // ---------------- device-bound path ----------------
    logic             in_full_q, in_full_d;
    logic [WIDTH-1:0] in_word_q;
    logic [TAGW-1:0]  in_tag;
    logic             tag_ok;
    logic             in_drop;

    assign in_tag        = in_word_q[WIDTH-1 -: TAGW];
    assign from_enq__RDY = ~in_full_q;
    assign rsp_enq_v     = in_word_q[PW-1:0];

    // Only a non-power-of-two channel count leaves tags that name no channel.
    generate
        if (NCHAN == (1 << TAGW)) begin : g_tag_full
            assign tag_ok = 1'b1;
        end else begin : g_tag_part
            assign tag_ok = (int'(in_tag) < NCHAN);
        end
    endgenerate

    assign in_drop = in_full_q & ~tag_ok;

    // Strobe the one sink named by the tag, when that sink is ready.
    always_comb begin
        rsp_enq__ENA = '0;
        for (int i = 0; i < NCHAN; i++) begin
            rsp_enq__ENA[i] = in_full_q && (in_tag == TAGW'(i)) && rsp_enq__RDY[i];
        end
    end

    // Inbound register empties on delivery or on drop of an unroutable word.
    always_comb begin
        in_full_d = in_full_q;
        if (from_enq__ENA) begin
            in_full_d = 1'b1;
        end else if ((|rsp_enq__ENA) || in_drop) begin
            in_full_d = 1'b0;
        end
    end

    // Inbound full flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) in_full_q <= 1'b0;
        else       in_full_q <= in_full_d;
    end

    // Inbound word capture.
    always_ff @(posedge CLK) begin
        if (from_enq__ENA) in_word_q <= from_enq_v;
    end

`ifdef BSCAN_CHAN_ARBITER_STATS_EN
    // ---------------- statistics ----------------
    logic [CNTW-1:0] sent_q, drop_q;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sent_q <= '0;
            drop_q <= '0;
        end else if (stat_clr) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (to_enq__ENA && (sent_q != '1)) sent_q <= sent_q + 1'b1;
            if (in_drop && (drop_q != '1))     drop_q <= drop_q + 1'b1;
        end
    end

    assign stat_sent = sent_q;
    assign stat_drop = drop_q;
`endif

endmodule

// File: tb/tb_bscan_chan_arbiter.sv
// Bench for bscan_chan_arbiter: directed table, corner sequences and a random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_bscan_chan_arbiter;
    import bscan_arb_pkg::*;

`ifdef BSCAN_CHAN_ARBITER_STATS_EN
    localparam int NCHAN = 3;
`else
    localparam int NCHAN = 4;
`endif
    localparam int WIDTH = 32;
    localparam int TAGW  = tag_width(NCHAN);
    localparam int PW    = WIDTH - TAGW;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [NCHAN-1:0]    req_enq__ENA;
    logic [NCHAN*PW-1:0] req_enq_v;
    logic [NCHAN-1:0]    req_enq__RDY;
    logic                to_enq__ENA;
    logic [WIDTH-1:0]    to_enq_v;
    logic                to_enq__RDY;
    logic                from_enq__ENA;
    logic [WIDTH-1:0]    from_enq_v;
    logic                from_enq__RDY;
    logic [NCHAN-1:0]    rsp_enq__ENA;
    logic [PW-1:0]       rsp_enq_v;
    logic [NCHAN-1:0]    rsp_enq__RDY;
    logic                stat_clr;
`ifdef BSCAN_CHAN_ARBITER_STATS_EN
    logic [CNTW-1:0]     stat_sent;
    logic [CNTW-1:0]     stat_drop;
`endif

    bscan_chan_arbiter #(.NCHAN(NCHAN), .WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .req_enq__ENA  (req_enq__ENA),
        .req_enq_v     (req_enq_v),
        .req_enq__RDY  (req_enq__RDY),
        .to_enq__ENA   (to_enq__ENA),
        .to_enq_v      (to_enq_v),
        .to_enq__RDY   (to_enq__RDY),
        .from_enq__ENA (from_enq__ENA),
        .from_enq_v    (from_enq_v),
        .from_enq__RDY (from_enq__RDY),
        .rsp_enq__ENA  (rsp_enq__ENA),
        .rsp_enq_v     (rsp_enq_v),
        .rsp_enq__RDY  (rsp_enq__RDY)
`ifdef BSCAN_CHAN_ARBITER_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_sent     (stat_sent),
        .stat_drop     (stat_drop)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec-level state) ----------------
    bit               m_full [NCHAN];
    logic [PW-1:0]    m_dat  [NCHAN];
    bit               m_ofull;
    logic [WIDTH-1:0] m_oword;
    int               m_rr;
    bit               m_ifull;
    logic [WIDTH-1:0] m_iword;
    int               m_sent, m_drop;

    task automatic model_reset();
        for (int i = 0; i < NCHAN; i++) m_full[i] = 1'b0;
        m_ofull = 1'b0; m_rr = 0; m_ifull = 1'b0; m_sent = 0; m_drop = 0;
    endtask

    function automatic logic [NCHAN-1:0] m_rdy();
        logic [NCHAN-1:0] r;
        for (int i = 0; i < NCHAN; i++) r[i] = !m_full[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] mkword(input int tag, input logic [PW-1:0] pay);
        hdr_t h;
        h.tag     = TAGW'(tag);
        h.payload = pay;
        return h;
    endfunction

    // Compare every DUT output with what the model says this cycle must show.
    task automatic model_check();
        int               tag;
        logic [NCHAN-1:0] exp_rsp;
        chk("req_rdy", 64'(req_enq__RDY), 64'(m_rdy()));
        chk("to_ena", 64'(to_enq__ENA), 64'(m_ofull && to_enq__RDY));
        if (m_ofull && to_enq__RDY) chk("to_v", 64'(to_enq_v), 64'(m_oword));
        chk("from_rdy", 64'(from_enq__RDY), 64'(!m_ifull));
        tag     = int'(m_iword[WIDTH-1 -: TAGW]);
        exp_rsp = '0;
        if (m_ifull && tag < NCHAN && rsp_enq__RDY[tag]) exp_rsp[tag] = 1'b1;
        chk("rsp_ena", 64'(rsp_enq__ENA), 64'(exp_rsp));
        if (exp_rsp != '0) chk("rsp_v", 64'(rsp_enq_v), 64'(m_iword[PW-1:0]));
`ifdef BSCAN_CHAN_ARBITER_STATS_EN
        chk("stat_sent", 64'(stat_sent), 64'(m_sent));
        chk("stat_drop", 64'(stat_drop), 64'(m_drop));
`endif
    endtask

    // Advance the model across one clock edge using the inputs of this cycle.
    task automatic model_step();
        int pick, j, tag;
        bit ten, load;
        pick = -1;
        for (int k = 0; k < NCHAN; k++) begin
            j = (m_rr + k) % NCHAN;
            if (pick < 0 && m_full[j]) pick = j;
        end
        ten  = m_ofull && to_enq__RDY;
        load = (pick >= 0) && (!m_ofull || ten);
        if (load) begin
            m_oword      = mkword(pick, m_dat[pick]);
            m_full[pick] = 1'b0;
            m_rr         = (pick + 1) % NCHAN;
            m_ofull      = 1'b1;
        end else if (ten) begin
            m_ofull = 1'b0;
        end
        for (int i = 0; i < NCHAN; i++) begin
            if (req_enq__ENA[i]) begin
                m_full[i] = 1'b1;
                m_dat[i]  = req_enq_v[i*PW +: PW];
            end
        end
        if (ten && m_sent < 65535) m_sent++;
        if (m_ifull) begin
            tag = int'(m_iword[WIDTH-1 -: TAGW]);
            if (tag >= NCHAN) begin
                m_ifull = 1'b0;
                if (m_drop < 65535) m_drop++;
            end else if (rsp_enq__RDY[tag]) begin
                m_ifull = 1'b0;
            end
        end
        if (from_enq__ENA) begin
            m_ifull = 1'b1;
            m_iword = from_enq_v;
        end
        if (stat_clr) begin
            m_sent = 0;
            m_drop = 0;
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    logic [NCHAN-1:0]    s_ena;
    logic [NCHAN*PW-1:0] s_v;
    logic                s_trdy, s_fena, s_clr;
    logic [WIDTH-1:0]    s_fv;
    logic [NCHAN-1:0]    s_rrdy;
    logic [WIDTH-1:0]    em_q  [$];
    logic [WIDTH-1:0]    exp_q [$];
    int                  pay_cnt = 1;

    task automatic stage_idle();
        s_ena = '0; s_v = '0; s_trdy = 1'b1; s_fena = 1'b0; s_fv = '0;
        s_rrdy = '1; s_clr = 1'b0;
    endtask

    // Stage enqueues on the given channels with unique payloads.
    task automatic mk_req(input logic [NCHAN-1:0] ena);
        s_ena = ena;
        s_v   = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (ena[i]) begin
                s_v[i*PW +: PW] = PW'(pay_cnt);
                exp_q.push_back(mkword(i, PW'(pay_cnt)));
                pay_cnt++;
            end
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, then advance the model.
    task automatic step();
        @(posedge CLK);
        #1;
        req_enq__ENA  = s_ena;
        req_enq_v     = s_v;
        to_enq__RDY   = s_trdy;
        from_enq__ENA = s_fena;
        from_enq_v    = s_fv;
        rsp_enq__RDY  = s_rrdy;
        stat_clr      = s_clr;
        @(negedge CLK);
        model_check();
        if (to_enq__ENA) em_q.push_back(to_enq_v);
        model_step();
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        req_enq__ENA = '0; req_enq_v = '0; to_enq__RDY = 1'b0; from_enq__ENA = 1'b0;
        from_enq_v = '0; rsp_enq__RDY = '0; stat_clr = 1'b0;
        nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        stage_idle();
        em_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int               ch;
        logic [PW-1:0]    pay;
        logic             trdy;
        logic             fena;
        logic [WIDTH-1:0] fv;
        logic [NCHAN-1:0] rrdy;
        logic [NCHAN-1:0] e_req_rdy;
        logic             e_to_ena;
        logic [WIDTH-1:0] e_to_v;
        logic             e_from_rdy;
        logic [NCHAN-1:0] e_rsp;
        logic [PW-1:0]    e_rsp_v;
    } vec_t;

    vec_t tv [13];

    initial begin
        logic [NCHAN-1:0] all1, ch2_busy, last_ch;
        logic [PW-1:0]    pay_a, pay_b;
        bit               found;
        int               tg;

        nRST = 1'b1;
        req_enq__ENA = '0; req_enq_v = '0; to_enq__RDY = 1'b0; from_enq__ENA = 1'b0;
        from_enq_v = '0; rsp_enq__RDY = '0; stat_clr = 1'b0;
        stage_idle();
        model_reset();

        all1     = '1;
        ch2_busy = all1;
        ch2_busy[2] = 1'b0;
        last_ch  = '0;
        last_ch[NCHAN-1] = 1'b1;
        pay_a = PW'(32'h0ABCDEF);
        pay_b = PW'(32'h0000123);

        for (int i = 0; i < 13; i++) begin
            tv[i] = '{ch: -1, pay: '0, trdy: 1'b1, fena: 1'b0, fv: '0, rrdy: all1,
                      e_req_rdy: all1, e_to_ena: 1'b0, e_to_v: '0, e_from_rdy: 1'b1,
                      e_rsp: '0, e_rsp_v: '0};
        end
        tv[1].ch = 2; tv[1].pay = pay_a;
        tv[2].e_req_rdy = ch2_busy;
        tv[3].e_to_ena = 1'b1; tv[3].e_to_v = mkword(2, pay_a);
        tv[5].fena = 1'b1; tv[5].fv = mkword(NCHAN - 1, pay_b); tv[5].rrdy = '0;
        for (int i = 6; i <= 10; i++) begin
            tv[i].rrdy = '0;
            tv[i].e_from_rdy = 1'b0;
        end
        tv[11].e_from_rdy = 1'b0; tv[11].e_rsp = last_ch; tv[11].e_rsp_v = pay_b;

        // Reset state, checked while reset is held.
        nRST = 1'b0;
        #12;
        chk("reset_req_rdy", 64'(req_enq__RDY), 64'(all1));
        chk("reset_to_ena", 64'(to_enq__ENA), 64'd0);
        chk("reset_from_rdy", 64'(from_enq__RDY), 64'd1);
        chk("reset_rsp_ena", 64'(rsp_enq__ENA), 64'd0);
        do_reset();

        // Single enqueue latency and inbound hold-then-deliver.
        for (int i = 0; i < 13; i++) begin
            stage_idle();
            s_trdy = tv[i].trdy; s_fena = tv[i].fena; s_fv = tv[i].fv; s_rrdy = tv[i].rrdy;
            s_v = '0;
            if (tv[i].ch >= 0) begin
                s_ena[tv[i].ch] = 1'b1;
                s_v[tv[i].ch*PW +: PW] = tv[i].pay;
            end
            step();
            chk($sformatf("tv%0d_req_rdy", i), 64'(req_enq__RDY), 64'(tv[i].e_req_rdy));
            chk($sformatf("tv%0d_to_ena", i), 64'(to_enq__ENA), 64'(tv[i].e_to_ena));
            if (tv[i].e_to_ena) chk($sformatf("tv%0d_to_v", i), 64'(to_enq_v), 64'(tv[i].e_to_v));
            chk($sformatf("tv%0d_from_rdy", i), 64'(from_enq__RDY), 64'(tv[i].e_from_rdy));
            chk($sformatf("tv%0d_rsp_ena", i), 64'(rsp_enq__ENA), 64'(tv[i].e_rsp));
            if (tv[i].e_rsp != '0) chk($sformatf("tv%0d_rsp_v", i), 64'(rsp_enq_v), 64'(tv[i].e_rsp_v));
        end

        // Fairness: all slots refilled as soon as they empty.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            stage_idle();
            mk_req(m_rdy());
            step();
        end
        chk("fair_count", 64'(em_q.size()), 64'd38);
        for (int k = 0; k < em_q.size(); k++) begin
            chk($sformatf("fair_tag%0d", k), 64'(em_q[k][WIDTH-1 -: TAGW]), 64'(k % NCHAN));
        end

        // Backpressure: everything fills, then drains with nothing lost or duplicated.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            stage_idle();
            s_trdy = 1'b0;
            mk_req(m_rdy());
            step();
            if (c >= 3) chk($sformatf("bp_rdy_low%0d", c), 64'(req_enq__RDY), 64'd0);
        end
        for (int c = 0; c < 10; c++) begin
            stage_idle();
            step();
        end
        chk("bp_count", 64'(em_q.size()), 64'(NCHAN + 1));
        for (int k = 0; k < em_q.size(); k++) begin
            found = 1'b0;
            for (int e = 0; e < exp_q.size(); e++) begin
                if (!found && exp_q[e] == em_q[k]) begin
                    found = 1'b1;
                    exp_q.delete(e);
                end
            end
            chk($sformatf("bp_word%0d_known", k), 64'(found), 64'd1);
        end
        chk("bp_none_left", 64'(exp_q.size()), 64'd0);

        // Mid-operation reset with both directions holding a word.
        do_reset();
        stage_idle();
        s_trdy = 1'b0; s_rrdy = '0;
        mk_req(2);
        s_fena = 1'b1; s_fv = mkword(0, PW'(32'h55));
        step();
        stage_idle();
        s_trdy = 1'b0; s_rrdy = '0;
        step();
        step();
        @(posedge CLK);
        #1;
        to_enq__RDY = 1'b1;
        rsp_enq__RDY = '1;
        #1;
        chk("prerst_to_ena", 64'(to_enq__ENA), 64'd1);
        chk("prerst_rsp_ena", 64'(rsp_enq__ENA), 64'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("midrst_to_ena", 64'(to_enq__ENA), 64'd0);
        chk("midrst_rsp_ena", 64'(rsp_enq__ENA), 64'd0);
        chk("midrst_req_rdy", 64'(req_enq__RDY), 64'(all1));
        chk("midrst_from_rdy", 64'(from_enq__RDY), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        em_q.delete();
        stage_idle();
        mk_req('1);
        step();
        stage_idle();
        for (int c = 0; c < 4; c++) step();
        chk("postrst_first_tag", (em_q.size() > 0) ? 64'(em_q[0][WIDTH-1 -: TAGW]) : 64'hDEAD, 64'd0);

`ifdef BSCAN_CHAN_ARBITER_STATS_EN
        // Unroutable tag is dropped after one cycle and counted; clear zeroes the counters.
        do_reset();
        stage_idle();
        s_fena = 1'b1; s_fv = mkword(3, PW'(32'h77));
        step();
        stage_idle();
        step();
        chk("drop_held_from_rdy", 64'(from_enq__RDY), 64'd0);
        chk("drop_no_rsp", 64'(rsp_enq__ENA), 64'd0);
        step();
        chk("drop_clear_from_rdy", 64'(from_enq__RDY), 64'd1);
        chk("drop_count", 64'(stat_drop), 64'd1);
        stage_idle();
        mk_req(1);
        step();
        stage_idle();
        step();
        step();
        step();
        chk("sent_count", 64'(stat_sent), 64'd1);
        stage_idle();
        s_clr = 1'b1;
        step();
        stage_idle();
        step();
        chk("clr_sent", 64'(stat_sent), 64'd0);
        chk("clr_drop", 64'(stat_drop), 64'd0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            stage_idle();
            s_ena = m_rdy() & NCHAN'($urandom);
            s_v   = '0;
            for (int i = 0; i < NCHAN; i++) s_v[i*PW +: PW] = PW'($urandom);
            s_trdy = ($urandom_range(0, 3) != 0);
            s_fena = !m_ifull && ($urandom_range(0, 1) == 1);
            tg     = $urandom_range(0, (1 << TAGW) - 1);
            s_fv   = mkword(tg, PW'($urandom));
            s_rrdy = NCHAN'($urandom);
            s_clr  = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
